// File: rtl/i2c_slave.sv
// I2C target endpoint: filtered SCL/SDA sampling, START/STOP detection, 7-bit address match,
// byte receive with ACK and byte transmit fed by a tx_req/tx_data handshake. SDA is open-drain.
module i2c_slave #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h42,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det,
  output logic       nack_rcvd
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK} state_t;

  state_t     state;
  logic [1:0] scl_sync, sda_sync;
  logic [3:0] scl_cnt, sda_cnt;
  logic       scl_f, sda_f, scl_q, sda_q;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic       byte_done, rw, first_arm, sda_oe;
  logic       scl_rise, scl_fall, start_cond, stop_cond;

  assign sda = sda_oe ? 1'b0 : 1'bz;

  // A level only propagates once it has been seen FILTER_LEN consecutive cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_cnt  <= '0;
      sda_cnt  <= '0;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      if (scl_sync[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == 4'(FILTER_LEN - 1)) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 4'd1;
      end
      if (sda_sync[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == 4'(FILTER_LEN - 1)) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 4'd1;
      end
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign scl_rise   = scl_f & ~scl_q;
  assign scl_fall   = ~scl_f & scl_q;
  assign start_cond = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_cond  = scl_f & scl_q & ~sda_q & sda_f;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift     <= '0;
      bit_cnt   <= 3'd7;
      byte_done <= 1'b0;
      rw        <= 1'b0;
      first_arm <= 1'b0;
      sda_oe    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_first  <= 1'b0;
      tx_req    <= 1'b0;
      busy      <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      nack_rcvd <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      rx_first  <= 1'b0;
      tx_req    <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      if (start_cond) begin
        state     <= ADDR;
        bit_cnt   <= 3'd7;
        shift     <= '0;
        byte_done <= 1'b0;
        nack_rcvd <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        start_det <= 1'b1;
      end else if (stop_cond) begin
        state     <= IDLE;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        stop_det  <= 1'b1;
      end else begin
        case (state)
          IDLE: sda_oe <= 1'b0;
          ADDR: begin
            if (scl_rise) begin
              shift <= {shift[6:0], sda_f};
              if (bit_cnt == 3'd0) byte_done <= 1'b1;
              else                 bit_cnt   <= bit_cnt - 3'd1;
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              if (shift[7:1] == SLAVE_ADDR) begin
                state  <= ADDR_ACK;
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                rw     <= shift[0];
              end else begin
                state  <= IDLE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_rise && rw) begin
              tx_req <= 1'b1;
            end else if (scl_fall) begin
              bit_cnt <= 3'd7;
              if (rw) begin
                shift  <= tx_data;
                sda_oe <= ~tx_data[7];
                state  <= TX;
              end else begin
                sda_oe    <= 1'b0;
                first_arm <= 1'b1;
                state     <= RX;
              end
            end
          end
          RX: begin
            if (scl_rise) begin
              shift <= {shift[6:0], sda_f};
              if (bit_cnt == 3'd0) begin
                rx_data   <= {shift[6:0], sda_f};
                rx_valid  <= 1'b1;
                rx_first  <= first_arm;
                first_arm <= 1'b0;
                byte_done <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
              end
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              sda_oe    <= 1'b1;
              state     <= RX_ACK;
            end
          end
          RX_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 3'd7;
              state   <= RX;
            end
          end
          TX: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                sda_oe <= 1'b0;
                state  <= TX_ACK;
              end else begin
                shift   <= {shift[6:0], 1'b0};
                sda_oe  <= ~shift[6];
                bit_cnt <= bit_cnt - 3'd1;
              end
            end
          end
          TX_ACK: begin
            // A NACK leaves this state on the rise, so any fall seen here follows an ACK.
            if (scl_rise) begin
              if (sda_f) begin
                nack_rcvd <= 1'b1;
                sda_oe    <= 1'b0;
                state     <= IDLE;
              end else begin
                tx_req <= 1'b1;
              end
            end else if (scl_fall) begin
              shift   <= tx_data;
              sda_oe  <= ~tx_data[7];
              bit_cnt <= 3'd7;
              state   <= TX;
            end
          end
          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
